// File: rtl/pc_msg_dispatcher_if.sv
// pc_msg_dispatcher_if: FIFO-side word handshake plus per-channel message delivery bus.
//   in_valid/in_data  FWFT word offered by the write FIFO; in_ack pops it
//   msg_data          assembled message, word 0 at the LSB
//   msg_valid/ready   one valid/ready pair per consumer channel
//   msg_stop          marks a broadcast STOP while it is being delivered
//   timeout_err       pulse when a partial message is discarded
//   drop_count        saturating count of timeouts and bad-channel drops
//   msg_count         wrapping count of delivered messages
//   master: environment (FIFO + consumers); slave: the dispatcher
interface pc_msg_dispatcher_if #(
    parameter int XB_SIZE   = 32,
    parameter int MSG_WORDS = 3,
    parameter int N_CH      = 4
);
    logic                         in_valid;
    logic [XB_SIZE-1:0]           in_data;
    logic                         in_ack;
    logic [MSG_WORDS*XB_SIZE-1:0] msg_data;
    logic [N_CH-1:0]              msg_valid;
    logic [N_CH-1:0]              msg_ready;
    logic                         msg_stop;
    logic                         timeout_err;
    logic [7:0]                   drop_count;
    logic [15:0]                  msg_count;

    modport master (
        output in_valid, in_data, msg_ready,
        input  in_ack, msg_data, msg_valid, msg_stop, timeout_err, drop_count, msg_count
    );

    modport slave (
        input  in_valid, in_data, msg_ready,
        output in_ack, msg_data, msg_valid, msg_stop, timeout_err, drop_count, msg_count
    );
endinterface

// File: rtl/pc_msg_dispatcher.sv
// pc_msg_dispatcher: assembles FIFO words into messages and dispatches them by channel field.
//   CLK    single clock
//   RESET  asynchronous active-low reset
//   bus    pc_msg_dispatcher_if.slave: FIFO word input, per-channel message output, status counters
module pc_msg_dispatcher #(
    parameter int XB_SIZE   = 32,
    parameter int MSG_WORDS = 3,
    parameter int N_CH      = 4,
    parameter int CH_LSB    = 88,
    parameter int TIMEOUT   = 1023
) (
    input logic                CLK,
    input logic                RESET,
    pc_msg_dispatcher_if.slave bus
);
    localparam int CHW = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam int IW  = MSG_WORDS > 1 ? $clog2(MSG_WORDS) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int MW  = MSG_WORDS * XB_SIZE;
    localparam logic [IW-1:0]   LAST = IW'(MSG_WORDS - 1);
    localparam logic [TW-1:0]   TLIM = TW'(TIMEOUT - 1);
    localparam logic [CHW:0]    NCH  = (CHW + 1)'(N_CH);
    localparam logic [N_CH-1:0] ONE  = N_CH'(1);

    typedef enum logic {COLLECT, DELIVER} state_t;

    state_t          r_state, w_state_nx;
    logic [IW-1:0]   r_idx;
    logic [TW-1:0]   r_idle;
    logic [MW-1:0]   r_data, w_data;
    logic [N_CH-1:0] r_mask, w_left;
    logic            r_stop, r_terr;
    logic [7:0]      r_drop;
    logic [15:0]     r_cnt;
    logic            w_ack, w_last, w_zero, w_good, w_take, w_bad, w_hit, w_done;
    logic [CHW-1:0]  w_ch;

    // Message as it will look once the word being acked lands in its slot
    always_comb begin
        w_data = r_data;
        w_data[int'(r_idx)*XB_SIZE +: XB_SIZE] = bus.in_data;
    end

    assign w_ack  = (r_state == COLLECT) && bus.in_valid;
    assign w_last = w_ack && (r_idx == LAST);
    assign w_ch   = w_data[CH_LSB +: CHW];
    assign w_zero = (w_data == '0);
    assign w_good = ({1'b0, w_ch} < NCH);
    assign w_take = w_last && (w_zero || w_good);
    assign w_bad  = w_last && !w_zero && !w_good;
    // An ack in the cycle the idle counter would reach TIMEOUT keeps the message alive
    assign w_hit  = (r_state == COLLECT) && !w_ack && (r_idx != '0) && (r_idle == TLIM);
    assign w_left = r_mask & ~bus.msg_ready;
    assign w_done = (r_state == DELIVER) && (w_left == '0);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= COLLECT;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (r_state == COLLECT) w_state_nx = w_take ? DELIVER : COLLECT;
        else                    w_state_nx = w_done ? COLLECT : DELIVER;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_idx  <= '0;
            r_idle <= '0;
            r_data <= '0;
            r_mask <= '0;
            r_stop <= 1'b0;
            r_terr <= 1'b0;
            r_drop <= '0;
            r_cnt  <= '0;
        end else begin
            r_terr <= w_hit;
            if (w_ack) begin
                r_data <= w_data;
                r_idx  <= w_last ? '0 : r_idx + 1'b1;
                r_idle <= '0;
            end else if (w_hit || r_idx == '0) begin
                r_idx  <= '0;
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end
            // Mask is zero outside DELIVER, so w_left also clears it when collecting
            if (w_take) begin
                r_mask <= w_zero ? '1 : ONE << w_ch;
                r_stop <= w_zero;
            end else begin
                r_mask <= w_left;
            end
            if ((w_hit || w_bad) && r_drop != 8'hff) r_drop <= r_drop + 8'd1;
            if (w_done) r_cnt <= r_cnt + 16'd1;
        end
    end

    assign bus.in_ack      = w_ack;
    assign bus.msg_data    = r_data;
    assign bus.msg_valid   = r_mask;
    assign bus.msg_stop    = r_stop && (r_mask != '0);
    assign bus.timeout_err = r_terr;
    assign bus.drop_count  = r_drop;
    assign bus.msg_count   = r_cnt;
endmodule
